// File: rtl/box_overlay_pkg.sv
// Shared constants for the box overlay stage:
// palette, pushbutton bit map, colour-index width.
package video_overlay_pkg;

  localparam int CIDX_W = 2;

  localparam int PB_LEFT   = 0;
  localparam int PB_RIGHT  = 1;
  localparam int PB_UP     = 2;
  localparam int PB_DOWN   = 3;
  localparam int PB_BOX    = 4;
  localparam int PB_COLOUR = 5;

  typedef logic [CIDX_W-1:0] cidx_t;

  // Channel-on mask per entry, {R,G,B}: white, red, green, blue.
  localparam logic [3:0][2:0] PALETTE = {
    3'b001, 3'b010, 3'b100, 3'b111
  };

  function automatic logic [2:0] pal_mask(cidx_t idx);
    return PALETTE[idx];
  endfunction

endpackage

// File: rtl/box_overlay_if.sv
// Video bundle: syncs, data enable and one RGB pixel.
// master drives the bundle, slave observes it.
interface box_overlay_if #(
  parameter int B = 8
);
  logic         vn;
  logic         hn;
  logic         den;
  logic [B-1:0] r;
  logic [B-1:0] g;
  logic [B-1:0] b;

  modport master (output vn, hn, den, r, g, b);
  modport slave  (input  vn, hn, den, r, g, b);
endinterface

// File: rtl/box_overlay_xy.sv
// Active-pixel position tracker: x from den runs,
// y from den falls, both restarted by the vs rise.
module active_xy_counter #(
  parameter int X_BITS = 12,
  parameter int Y_BITS = 12
) (
  input  logic              clk,
  input  logic              reset,
  box_overlay_if.slave      vid,
  output logic [X_BITS-1:0] o_x,
  output logic [Y_BITS-1:0] o_y,
  output logic              o_vs_rise
);

  localparam logic [X_BITS-1:0] X_SAT = '1;
  localparam logic [Y_BITS-1:0] Y_SAT = '1;

  logic              r_den_d;
  logic              r_vn_d;
  logic [X_BITS-1:0] r_h_cnt;
  logic [Y_BITS-1:0] r_v_cnt;
  logic              w_den_rise;
  logic              w_den_fall;

  assign w_den_rise = vid.den & ~r_den_d;
  assign w_den_fall = ~vid.den & r_den_d;
  assign o_vs_rise  = vid.vn & ~r_vn_d;

  // r_h_cnt holds the x of the next pixel; the
  // first pixel of a run is forced to 0.
  assign o_x = w_den_rise ? '0 : r_h_cnt;
  assign o_y = r_v_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_den_d <= 1'b0;
      r_vn_d  <= 1'b0;
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      r_den_d <= vid.den;
      r_vn_d  <= vid.vn;
      if (vid.den) begin
        r_h_cnt <= (o_x == X_SAT) ? X_SAT
                 : o_x + X_BITS'(1);
      end
      if (o_vs_rise) begin
        r_v_cnt <= '0;
      end else if (w_den_fall && r_v_cnt != Y_SAT) begin
        r_v_cnt <= r_v_cnt + Y_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/box_overlay.sv
// Solid-colour box overlay, 2-cycle pixel pipeline.
// Box position, enable and colour change once per frame.
module box_overlay
  import video_overlay_pkg::*;
#(
  parameter int B      = 8,
  parameter int X_BITS = 12,
  parameter int Y_BITS = 12,
  parameter int ACT_W  = 1280,
  parameter int ACT_H  = 720,
  parameter int BOX_W  = 64,
  parameter int BOX_H  = 64,
  parameter int STEP   = 4
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic         vn_in,
  input  logic         hn_in,
  input  logic         dn_in,
  input  logic [B-1:0] r_in,
  input  logic [B-1:0] g_in,
  input  logic [B-1:0] b_in,
  input  logic [5:0]   pb,
  output logic         vn_out,
  output logic         hn_out,
  output logic         den_out,
  output logic [B-1:0] r_out,
  output logic [B-1:0] g_out,
  output logic [B-1:0] b_out
);

  localparam logic [X_BITS:0] X_LIM  = (X_BITS+1)'(ACT_W - BOX_W);
  localparam logic [Y_BITS:0] Y_LIM  = (Y_BITS+1)'(ACT_H - BOX_H);
  localparam logic [X_BITS:0] X_STEP = (X_BITS+1)'(STEP);
  localparam logic [Y_BITS:0] Y_STEP = (Y_BITS+1)'(STEP);
  localparam logic [X_BITS:0] X_BOX  = (X_BITS+1)'(BOX_W);
  localparam logic [Y_BITS:0] Y_BOX  = (Y_BITS+1)'(BOX_H);

  typedef struct packed {
    logic [X_BITS-1:0] x_pos;
    logic [Y_BITS-1:0] y_pos;
    logic              en;
    cidx_t             col;
    logic [5:0]        pb_q;
  } ctl_t;

  localparam ctl_t CTL_RST = '{
    x_pos: X_BITS'((ACT_W - BOX_W) / 2),
    y_pos: Y_BITS'((ACT_H - BOX_H) / 2),
    en:    1'b1,
    col:   '0,
    pb_q:  '0
  };

  box_overlay_if #(.B(B)) u_vin ();

  assign u_vin.vn  = vn_in;
  assign u_vin.hn  = hn_in;
  assign u_vin.den = dn_in;
  assign u_vin.r   = r_in;
  assign u_vin.g   = g_in;
  assign u_vin.b   = b_in;

  logic [X_BITS-1:0] w_x;
  logic [Y_BITS-1:0] w_y;
  logic              w_vs_rise;

  active_xy_counter #(
    .X_BITS (X_BITS),
    .Y_BITS (Y_BITS)
  ) u_xy (
    .clk       (clk_in),
    .reset     (reset),
    .vid       (u_vin),
    .o_x       (w_x),
    .o_y       (w_y),
    .o_vs_rise (w_vs_rise)
  );

  ctl_t r_ctl;
  ctl_t w_ctl_n;

  logic [X_BITS:0] w_xe;
  logic [Y_BITS:0] w_ye;
  logic [X_BITS:0] w_x_inc;
  logic [Y_BITS:0] w_y_inc;

  assign w_xe    = {1'b0, r_ctl.x_pos};
  assign w_ye    = {1'b0, r_ctl.y_pos};
  assign w_x_inc = w_xe + X_STEP;
  assign w_y_inc = w_ye + Y_STEP;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_ctl <= CTL_RST;
    end else begin
      r_ctl <= w_ctl_n;
    end
  end

  // Opposing buttons cancel; moves clamp to the active area.
  always_comb begin
    w_ctl_n = r_ctl;
    if (w_vs_rise) begin
      case ({pb[PB_RIGHT], pb[PB_LEFT]})
        2'b01: w_ctl_n.x_pos = (w_xe < X_STEP) ? '0
                             : X_BITS'(w_xe - X_STEP);
        2'b10: w_ctl_n.x_pos = (w_x_inc > X_LIM)
                             ? X_BITS'(X_LIM)
                             : X_BITS'(w_x_inc);
        default: ;
      endcase
      case ({pb[PB_DOWN], pb[PB_UP]})
        2'b01: w_ctl_n.y_pos = (w_ye < Y_STEP) ? '0
                             : Y_BITS'(w_ye - Y_STEP);
        2'b10: w_ctl_n.y_pos = (w_y_inc > Y_LIM)
                             ? Y_BITS'(Y_LIM)
                             : Y_BITS'(w_y_inc);
        default: ;
      endcase
      if (pb[PB_BOX] && !r_ctl.pb_q[PB_BOX]) begin
        w_ctl_n.en = ~r_ctl.en;
      end
      if (pb[PB_COLOUR] && !r_ctl.pb_q[PB_COLOUR]) begin
        w_ctl_n.col = r_ctl.col + cidx_t'(1);
      end
      w_ctl_n.pb_q = pb;
    end
  end

  logic              r_s1_vn;
  logic              r_s1_hn;
  logic              r_s1_den;
  logic [B-1:0]      r_s1_r;
  logic [B-1:0]      r_s1_g;
  logic [B-1:0]      r_s1_b;
  logic [X_BITS-1:0] r_s1_x;
  logic [Y_BITS-1:0] r_s1_y;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_s1_vn  <= 1'b0;
      r_s1_hn  <= 1'b0;
      r_s1_den <= 1'b0;
      r_s1_r   <= '0;
      r_s1_g   <= '0;
      r_s1_b   <= '0;
      r_s1_x   <= '0;
      r_s1_y   <= '0;
    end else begin
      r_s1_vn  <= u_vin.vn;
      r_s1_hn  <= u_vin.hn;
      r_s1_den <= u_vin.den;
      r_s1_r   <= u_vin.r;
      r_s1_g   <= u_vin.g;
      r_s1_b   <= u_vin.b;
      r_s1_x   <= w_x;
      r_s1_y   <= w_y;
    end
  end

  logic [X_BITS:0] w_s1_xe;
  logic [Y_BITS:0] w_s1_ye;
  logic            w_hit;
  logic [2:0]      w_mask;
  logic [B-1:0]    w_r;
  logic [B-1:0]    w_g;
  logic [B-1:0]    w_b;

  assign w_s1_xe = {1'b0, r_s1_x};
  assign w_s1_ye = {1'b0, r_s1_y};

  always_comb begin
    w_hit = r_ctl.en & r_s1_den
          & (w_s1_xe >= w_xe) & (w_s1_xe < w_xe + X_BOX)
          & (w_s1_ye >= w_ye) & (w_s1_ye < w_ye + Y_BOX);
    w_mask = pal_mask(r_ctl.col);
    w_r = r_s1_r;
    w_g = r_s1_g;
    w_b = r_s1_b;
    if (w_hit) begin
      w_r = {B{w_mask[2]}};
      w_g = {B{w_mask[1]}};
      w_b = {B{w_mask[0]}};
    end
  end

  logic         r_vn_o;
  logic         r_hn_o;
  logic         r_den_o;
  logic [B-1:0] r_r_o;
  logic [B-1:0] r_g_o;
  logic [B-1:0] r_b_o;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_vn_o  <= 1'b0;
      r_hn_o  <= 1'b0;
      r_den_o <= 1'b0;
      r_r_o   <= '0;
      r_g_o   <= '0;
      r_b_o   <= '0;
    end else begin
      r_vn_o  <= r_s1_vn;
      r_hn_o  <= r_s1_hn;
      r_den_o <= r_s1_den;
      r_r_o   <= w_r;
      r_g_o   <= w_g;
      r_b_o   <= w_b;
    end
  end

  assign vn_out  = r_vn_o;
  assign hn_out  = r_hn_o;
  assign den_out = r_den_o;
  assign r_out   = r_r_o;
  assign g_out   = r_g_o;
  assign b_out   = r_b_o;

endmodule

// File: tb/tb_box_overlay.sv
// Bench for box_overlay on a reduced raster, scored
// against a frame-level model of position and colour.
module tb_box_overlay;

  localparam int B  = 8;
  localparam int AW = 48;
  localparam int AH = 20;
  localparam int BW = 8;
  localparam int BH = 4;
  localparam int ST = 4;
  localparam int AREA = BW * BH;

  logic         clk = 1'b0;
  logic         reset;
  logic [5:0]   pb;
  logic         vn_out, hn_out, den_out;
  logic [B-1:0] r_out, g_out, b_out;

  always #5 clk = ~clk;

  box_overlay_if #(.B(B)) u_if ();

  box_overlay #(
    .B(B), .X_BITS(12), .Y_BITS(12),
    .ACT_W(AW), .ACT_H(AH),
    .BOX_W(BW), .BOX_H(BH), .STEP(ST)
  ) dut (
    .clk_in  (clk),
    .reset   (reset),
    .vn_in   (u_if.vn),
    .hn_in   (u_if.hn),
    .dn_in   (u_if.den),
    .r_in    (u_if.r),
    .g_in    (u_if.g),
    .b_in    (u_if.b),
    .pb      (pb),
    .vn_out  (vn_out),
    .hn_out  (hn_out),
    .den_out (den_out),
    .r_out   (r_out),
    .g_out   (g_out),
    .b_out   (b_out)
  );

  typedef struct packed {
    logic       vn, hn, den;
    logic [7:0] r, g, b;
  } pix_t;

  pix_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   bad;
  int   odd;
  string first_bad;

  int   m_xpos, m_ypos, m_h, m_v, m_col;
  bit   m_en, m_pvn, m_pden;
  bit [5:0] m_pbq;

  task automatic model_reset();
    m_xpos = (AW - BW) / 2;
    m_ypos = (AH - BH) / 2;
    m_en = 1'b1;
    m_col = 0;
    m_pbq = '0;
    m_h = 0;
    m_v = 0;
    m_pvn = 1'b0;
    m_pden = 1'b0;
    q.delete();
  endtask

  task automatic frame_event();
    if (pb[0] && !pb[1])
      m_xpos = (m_xpos >= ST) ? m_xpos - ST : 0;
    if (pb[1] && !pb[0])
      m_xpos = (m_xpos + ST > AW - BW) ? AW - BW : m_xpos + ST;
    if (pb[2] && !pb[3])
      m_ypos = (m_ypos >= ST) ? m_ypos - ST : 0;
    if (pb[3] && !pb[2])
      m_ypos = (m_ypos + ST > AH - BH) ? AH - BH : m_ypos + ST;
    if (pb[4] && !m_pbq[4]) m_en = !m_en;
    if (pb[5] && !m_pbq[5]) m_col = (m_col + 1) % 4;
    m_pbq = pb;
  endtask

  task automatic model_step(
    input logic vn, hn, den,
    input logic [7:0] r, g, b,
    output pix_t e
  );
    int x, y;
    e = {vn, hn, den, r, g, b};
    if (den) begin
      if (!m_pden) m_h = 0;
      x = m_h;
      y = m_v;
      m_h++;
      if (m_en && x >= m_xpos && x < m_xpos + BW &&
          y >= m_ypos && y < m_ypos + BH) begin
        case (m_col)
          0: {e.r, e.g, e.b} = 24'hFFFFFF;
          1: {e.r, e.g, e.b} = 24'hFF0000;
          2: {e.r, e.g, e.b} = 24'h00FF00;
          default: {e.r, e.g, e.b} = 24'h0000FF;
        endcase
      end
    end
    if (!den && m_pden) m_v++;
    if (vn && !m_pvn) begin
      m_v = 0;
      frame_event();
    end
    m_pden = den;
    m_pvn = vn;
  endtask

  // One pixel clock: score the output due now, then
  // apply the next input and queue its expected output.
  task automatic drive(
    input logic vn, hn, den,
    input logic [7:0] r, g, b
  );
    pix_t e, o;
    @(negedge clk);
    if (q.size() == 2) begin
      e = q.pop_front();
      o = {vn_out, hn_out, den_out, r_out, g_out, b_out};
      if (o !== e) begin
        if (bad == 0)
          first_bad = $sformatf("got %h want %h", o, e);
        bad++;
      end
      if (den_out && {r_out, g_out, b_out} !== 24'h202020)
        odd++;
    end
    u_if.vn = vn;
    u_if.hn = hn;
    u_if.den = den;
    u_if.r = r;
    u_if.g = g;
    u_if.b = b;
    model_step(vn, hn, den, r, g, b, e);
    q.push_back(e);
  endtask

  function automatic logic [7:0] px(input bit rnd);
    return rnd ? 8'($urandom) : 8'h20;
  endfunction

  task automatic full_frame(input bit rnd);
    repeat (2) drive(1, 0, 0, px(rnd), px(rnd), px(rnd));
    repeat (3) drive(0, 0, 0, px(rnd), px(rnd), px(rnd));
    for (int ln = 0; ln < AH; ln++) begin
      for (int i = 0; i < AW; i++)
        drive(0, 0, 1, px(rnd), px(rnd), px(rnd));
      for (int k = 0; k < 4; k++)
        drive(0, (k == 1 || k == 2), 0,
              px(rnd), px(rnd), px(rnd));
    end
    repeat (4) drive(0, 0, 0, px(rnd), px(rnd), px(rnd));
  endtask

  task automatic short_frames(input int n);
    repeat (n) begin
      repeat (2) drive(1, 0, 0, px(1), px(1), px(1));
      repeat (2) drive(0, 0, 0, px(1), px(1), px(1));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pb = '0;
    u_if.vn = 0; u_if.hn = 0; u_if.den = 0;
    u_if.r = 8'h55; u_if.g = 8'hAA; u_if.b = 8'h33;
    repeat (3) @(negedge clk);
    n_chk++;
    if (vn_out !== 1'b0) $display("FAIL reset vn_out got %b want 0", vn_out);
    else n_pass++;
    n_chk++;
    if (hn_out !== 1'b0) $display("FAIL reset hn_out got %b want 0", hn_out);
    else n_pass++;
    n_chk++;
    if (den_out !== 1'b0) $display("FAIL reset den_out got %b want 0", den_out);
    else n_pass++;
    n_chk++;
    if (r_out !== 8'h0) $display("FAIL reset r_out got %h want 00", r_out);
    else n_pass++;
    n_chk++;
    if (g_out !== 8'h0) $display("FAIL reset g_out got %h want 00", g_out);
    else n_pass++;
    n_chk++;
    if (b_out !== 8'h0) $display("FAIL reset b_out got %h want 00", b_out);
    else n_pass++;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_centre();
    bad = 0; odd = 0; pb = '0;
    full_frame(0);
    n_chk++;
    if (bad !== 0) $display("FAIL centre pixels: %0d bad, first %s", bad, first_bad);
    else n_pass++;
    n_chk++;
    if (odd !== AREA) $display("FAIL centre box size got %0d want %0d", odd, AREA);
    else n_pass++;
  endtask

  task automatic test_left_clamp();
    bad = 0; odd = 0; pb = 6'b000001;
    short_frames(30);
    full_frame(0);
    n_chk++;
    if (bad !== 0) $display("FAIL left pixels: %0d bad, first %s", bad, first_bad);
    else n_pass++;
    n_chk++;
    if (odd !== AREA) $display("FAIL left box size got %0d want %0d", odd, AREA);
    else n_pass++;
  endtask

  task automatic test_opposing_and_down();
    bad = 0; pb = 6'b000011;
    short_frames(5);
    full_frame(1);
    n_chk++;
    if (bad !== 0) $display("FAIL opposing pixels: %0d bad, first %s", bad, first_bad);
    else n_pass++;
    bad = 0; odd = 0; pb = 6'b001000;
    short_frames(10);
    full_frame(0);
    n_chk++;
    if (bad !== 0) $display("FAIL down pixels: %0d bad, first %s", bad, first_bad);
    else n_pass++;
    n_chk++;
    if (odd !== AREA) $display("FAIL down box size got %0d want %0d", odd, AREA);
    else n_pass++;
  endtask

  task automatic test_right_clamp();
    bad = 0; odd = 0; pb = 6'b000010;
    short_frames(15);
    full_frame(0);
    n_chk++;
    if (bad !== 0) $display("FAIL right pixels: %0d bad, first %s", bad, first_bad);
    else n_pass++;
    n_chk++;
    if (odd !== AREA) $display("FAIL right box size got %0d want %0d", odd, AREA);
    else n_pass++;
  endtask

  task automatic test_toggle();
    bad = 0; odd = 0; pb = 6'b010000;
    short_frames(4);
    full_frame(0);
    n_chk++;
    if (bad !== 0) $display("FAIL toggle-off pixels: %0d bad, first %s", bad, first_bad);
    else n_pass++;
    n_chk++;
    if (odd !== 0) $display("FAIL toggle-off box size got %0d want 0", odd);
    else n_pass++;
    bad = 0; odd = 0;
    pb = '0; short_frames(1);
    pb = 6'b010000; short_frames(1);
    pb = '0;
    full_frame(0);
    n_chk++;
    if (bad !== 0) $display("FAIL toggle-on pixels: %0d bad, first %s", bad, first_bad);
    else n_pass++;
    n_chk++;
    if (odd !== AREA) $display("FAIL toggle-on box size got %0d want %0d", odd, AREA);
    else n_pass++;
  endtask

  task automatic test_colour();
    for (int i = 0; i < 5; i++) begin
      bad = 0; odd = 0;
      pb = 6'b100000; short_frames(1);
      pb = '0; short_frames(1);
      full_frame(0);
      n_chk++;
      if (bad !== 0) $display("FAIL colour%0d pixels: %0d bad, first %s", i, bad, first_bad);
      else n_pass++;
      n_chk++;
      if (odd !== AREA) $display("FAIL colour%0d box size got %0d want %0d", i, odd, AREA);
      else n_pass++;
    end
  endtask

  task automatic test_midline_reset();
    bad = 0; odd = 0;
    pb = 6'b000001; short_frames(12);
    pb = 6'b000100; short_frames(5);
    pb = '0;
    repeat (2) drive(1, 0, 0, px(1), px(1), px(1));
    repeat (3) drive(0, 0, 0, px(1), px(1), px(1));
    repeat (10) drive(0, 0, 1, px(1), px(1), px(1));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({vn_out, hn_out, den_out, r_out, g_out, b_out} !== 27'h0)
      $display("FAIL midreset outputs got %h want 0",
               {vn_out, hn_out, den_out, r_out, g_out, b_out});
    else n_pass++;
    n_chk++;
    if (bad !== 0) $display("FAIL pre-reset pixels: %0d bad, first %s", bad, first_bad);
    else n_pass++;
    u_if.vn = 0; u_if.hn = 0; u_if.den = 0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    bad = 0; odd = 0;
    full_frame(0);
    n_chk++;
    if (bad !== 0) $display("FAIL post-reset pixels: %0d bad, first %s", bad, first_bad);
    else n_pass++;
    n_chk++;
    if (odd !== AREA) $display("FAIL post-reset box size got %0d want %0d", odd, AREA);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_centre();
    test_left_clamp();
    test_opposing_and_down();
    test_right_clamp();
    test_toggle();
    test_colour();
    test_midline_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/box_overlay.md
Name: box_overlay

Overview:
- Post-processing stage between the pattern generator outputs (vn/hn/den, 8-bit RGB) and the ADV7511 output registers.
- Tracks the active-pixel position itself from den/vs and overlays a solid-colour box.
- Pushbuttons pb[5:0] steer the box, toggle it, and cycle its colour, once per frame.
- Sync/DE pass through with the same latency as the pixel data.

Parameters:
- B, 8, bits per colour channel
- X_BITS, 12, width of horizontal position/counter
- Y_BITS, 12, width of vertical position/counter
- ACT_W, 1280, active pixels per line
- ACT_H, 720, active lines per frame
- BOX_W, 64, box width in pixels
- BOX_H, 64, box height in lines
- STEP, 4, pixels/lines moved per frame while a direction button is held

Ports:
- clk_in  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- vn_in  in  1  vertical sync from pattern stage, active high
- hn_in  in  1  horizontal sync from pattern stage
- dn_in  in  1  data enable from pattern stage
- r_in, g_in, b_in  in  B each  pixel colour from pattern stage
- pb  in  6  pushbuttons: [0] left, [1] right, [2] up, [3] down, [4] box on/off, [5] next colour
- vn_out, hn_out, den_out  out  1 each  syncs/DE delayed 2 cycles
- r_out, g_out, b_out  out  B each  overlaid pixel, 2-cycle latency

Behaviour:
- Reset state (synchronous, reset=1 on a clk_in edge):
  - All outputs 0.
  - Box position x_pos=(ACT_W-BOX_W)/2, y_pos=(ACT_H-BOX_H)/2.
  - Box enabled, colour index 0.
  - Counters 0; pb history 0.
- Reset mid-frame: the first frame after release draws nothing correct until the next vn_in rising edge. Counters resume only from the next den/vs edges.
- Position tracking:
  - h_cnt clears to 0 on the cycle after dn_in rises; the first active pixel has x=0.
  - h_cnt increments each cycle dn_in=1 and saturates at 2^X_BITS-1.
  - v_cnt increments on each dn_in falling edge.
  - v_cnt clears on vn_in rising edge and saturates at 2^Y_BITS-1.
- Frame event: vn_in rising edge, detected from a registered copy. At that cycle only:
  - pb is sampled.
  - Left and right held together: no horizontal move. Up and down held together: no vertical move.
  - Left: x_pos := x_pos-STEP, clamped at 0. Right: x_pos := x_pos+STEP, clamped at ACT_W-BOX_W. Up/down: same rule on y_pos with ACT_H-BOX_H.
  - Sums are computed at X_BITS+1 / Y_BITS+1 bits so they cannot wrap.
  - pb[4] rising, sampled vs previous frame sample: enable toggles.
  - pb[5] rising: colour index increments mod 4.
  - Holding a toggle button produces exactly one toggle.
- Position changes never occur mid-frame, so there is no tearing.
- Palette: 0 white (all ones), 1 red, 2 green, 3 blue. Non-primary channels are 0.
- Pipeline:
  - Stage 1 registers the inputs plus the current (x,y).
  - Stage 2 computes hit = enable & den & x_pos<=x<x_pos+BOX_W & y_pos<=y<y_pos+BOX_H.
  - Stage 2 outputs the palette colour on a hit, else the stage-1 RGB.
  - Syncs/DE are delayed identically.
  - While den_out=0, RGB passes through unmodified.
- Box at the clamp edge: the last box column is exactly ACT_W-1 and the last row ACT_H-1. Nothing is drawn outside the active area.

Decomposition:
- Package video_overlay_pkg:
  - Palette constants (4 entries × 3 channels, B-bit).
  - pb bit index constants (PB_LEFT..PB_COLOUR).
  - Colour-index width (2).
- Sub-module active_xy_counter: derives x/y from dn_in/vn_in, using the den edge detect, saturating counters and the vs-rise pulse output. box_overlay instantiates it and holds the position/button FSM and the 2-stage mux.

Test Plan:
- Reset, then a 1280×720 frame of constant RGB 0x202020, no buttons -> white pixels exactly at x 608..671, y 328..391. All other active pixels 0x202020. vn/hn/den_out equal the inputs delayed 2 cycles.
- Hold pb[0] for 200 frames -> x_pos decreases by 4 per frame, reaches 0 at frame 152, then stays 0. Box occupies x 0..63.
- Hold pb[1] and pb[0] together for 10 frames -> x_pos unchanged. Then hold pb[3] 100 frames -> y_pos = 656 (clamped); box rows 656..719.
- Hold pb[4] for 5 frames -> box disabled after the first frame event only (one toggle). Output equals the input pattern. Release and press again -> box reappears.
- Press pb[5] 5 times (each separate frames) -> colours go red, green, blue, white, red; red box = R 0xFF, G 0, B 0.
- Assert reset mid-line with the box moved to (0,0) -> the next cycle all outputs are 0. After release and the next vs rise, the box is at centre (608,328) in white.
